// File: rtl/stepper_pkg.sv
// Shared types and microstep codes for the stepper array.
// Position counters are built only when STEPPER_POS_EN is defined.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } stepper_state_t;

  localparam logic [2:0] MS_FULL      = 3'b000;
  localparam logic [2:0] MS_HALF      = 3'b100;
  localparam logic [2:0] MS_QUARTER   = 3'b010;
  localparam logic [2:0] MS_EIGHTH    = 3'b110;
  localparam logic [2:0] MS_SIXTEENTH = 3'b111;

endpackage

// File: rtl/stepper_channel.sv
// One motor channel: speed ramp, phase accumulator, pulse timer, dir hold.
// Optional position counter under STEPPER_POS_EN.
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int SPEED_W   = 10,
  parameter int ACC_W     = 24,
  parameter int ACCEL     = 4,
  parameter int PULSE_W   = 200,
  parameter int DIR_SETUP = 100
`ifdef STEPPER_POS_EN
  ,
  parameter int POS_W     = 32
`endif
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      run,
  input  logic                      tick,
  input  logic signed [SPEED_W-1:0] target,
`ifdef STEPPER_POS_EN
  input  logic                      pos_clr,
  output logic        [POS_W-1:0]   pos,
`endif
  output logic                      step,
  output logic                      dir,
  output logic                      at_speed,
  output logic                      idle
);

  localparam int SW = ACC_W + SPEED_W;
  localparam int PW = $clog2(PULSE_W + 1);
  localparam int HW = (DIR_SETUP > 0) ? $clog2(DIR_SETUP + 1) : 1;

  localparam logic signed [SPEED_W-1:0] S_MIN =
    {1'b1, {(SPEED_W-1){1'b0}}};
  localparam logic signed [SPEED_W-1:0] S_FLOOR =
    {1'b1, {(SPEED_W-2){1'b0}}, 1'b1};

  logic signed [SPEED_W-1:0] cur;
  logic signed [SPEED_W-1:0] eff;
  logic signed [SPEED_W-1:0] cur_nxt;
  logic        [SPEED_W-1:0] mag;
  logic        [ACC_W-1:0]   acc;
  logic        [SW-1:0]      sum;
  logic                      carry;
  logic                      pend;
  logic                      want_dir;
  logic                      fire;
  logic        [PW-1:0]      pcnt;
  logic        [HW-1:0]      hold;
  int                        d;
  int                        n;

  assign eff = !run ? '0 : (target == S_MIN) ? S_FLOOR : target;

  // Speed never jumps across zero; it lands on 0 first.
  always_comb begin
    d = int'(eff) - int'(cur);
    if (d > ACCEL) d = ACCEL;
    else if (d < -ACCEL) d = -ACCEL;
    n = int'(cur) + d;
    if ((cur > 0 && n < 0) || (cur < 0 && n > 0)) n = 0;
    cur_nxt = SPEED_W'(n);
  end

  assign mag      = cur[SPEED_W-1] ? SPEED_W'(-cur) : SPEED_W'(cur);
  assign sum      = SW'(acc) + SW'(mag);
  assign carry    = |sum[SW-1:ACC_W];
  assign want_dir = ~cur[SPEED_W-1];
  assign fire     = pend && !step && hold == '0 && dir == want_dir;
  assign idle     = (cur == '0) && !step;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur      <= '0;
      acc      <= '0;
      pend     <= 1'b0;
      step     <= 1'b0;
      pcnt     <= '0;
      dir      <= 1'b1;
      hold     <= '0;
      at_speed <= 1'b0;
    end else begin
      if (tick) cur <= cur_nxt;
      at_speed <= (cur == eff);

      if (cur == '0) begin
        acc  <= '0;
        pend <= 1'b0;
      end else begin
        acc  <= sum[ACC_W-1:0];
        pend <= carry | (pend & ~fire);
      end

      if (step) begin
        if (pcnt == '0) step <= 1'b0;
        else pcnt <= pcnt - 1'b1;
      end else if (fire) begin
        step <= 1'b1;
        pcnt <= PW'(PULSE_W - 1);
      end

      // A running pulse finishes before dir may flip.
      if (!step && dir != want_dir) begin
        dir  <= want_dir;
        hold <= HW'(DIR_SETUP);
      end else if (hold != '0) begin
        hold <= hold - 1'b1;
      end
    end
  end

`ifdef STEPPER_POS_EN
  always_ff @(posedge clock) begin
    if (!reset_n || pos_clr) pos <= '0;
    else if (fire) pos <= dir ? pos + 1'b1 : pos - 1'b1;
  end
`endif

endmodule

// File: rtl/stepper_array.sv
// N-channel step/dir generator: shared enable/microstep FSM and ramp tick.
// Define STEPPER_POS_EN to add per-channel position counters.
module stepper_array
  import stepper_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int SPEED_W   = 10,
  parameter int ACC_W     = 24,
  parameter int RAMP_DIV  = 100000,
  parameter int ACCEL     = 4,
  parameter int PULSE_W   = 200,
  parameter int DIR_SETUP = 100
`ifdef STEPPER_POS_EN
  ,
  parameter int POS_W     = 32
`endif
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      run_en,
  input  logic [N_CH*SPEED_W-1:0]   target_speed,
  input  logic [2:0]                microstep,
`ifdef STEPPER_POS_EN
  input  logic                      pos_clr,
  output logic [N_CH*POS_W-1:0]     pos,
`endif
  output logic [N_CH-1:0]           step,
  output logic [N_CH-1:0]           dir,
  output logic                      en_n,
  output logic [2:0]                ms,
  output logic [N_CH-1:0]           at_speed
);

  localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  stepper_state_t    state;
  logic [TW-1:0]     tcnt;
  logic              tick;
  logic [N_CH-1:0]   ch_idle;

  assign tick = (state != IDLE) && (tcnt == TW'(RAMP_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      en_n  <= 1'b1;
      ms    <= MS_FULL;
      tcnt  <= '0;
    end else begin
      if (state == IDLE || tick) tcnt <= '0;
      else tcnt <= tcnt + 1'b1;

      unique case (state)
        IDLE: begin
          ms <= microstep;
          if (run_en) begin
            state <= RUN;
            en_n  <= 1'b0;
          end
        end
        RUN: if (!run_en) state <= STOP;
        STOP: begin
          if (run_en) begin
            state <= RUN;
          end else if (&ch_idle) begin
            state <= IDLE;
            en_n  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    stepper_channel #(
      .SPEED_W  (SPEED_W),
      .ACC_W    (ACC_W),
      .ACCEL    (ACCEL),
      .PULSE_W  (PULSE_W),
      .DIR_SETUP(DIR_SETUP)
`ifdef STEPPER_POS_EN
      ,
      .POS_W    (POS_W)
`endif
    ) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
      .run     (state == RUN),
      .tick    (tick),
      .target  (target_speed[i*SPEED_W +: SPEED_W]),
`ifdef STEPPER_POS_EN
      .pos_clr (pos_clr),
      .pos     (pos[i*POS_W +: POS_W]),
`endif
      .step    (step[i]),
      .dir     (dir[i]),
      .at_speed(at_speed[i]),
      .idle    (ch_idle[i])
    );
  end

endmodule
